// File: rtl/gfx_fp_stream_pkg.sv
// Shared gfx FP definitions used by the stream adapter: the fp operand type
// and the stage count of the gfx FP adder.
`ifndef FP_ADD_STAGES
`define FP_ADD_STAGES 4
`endif

package gfx_fp_stream_pkg;
  typedef logic [31:0] fp;
  localparam int unsigned FP_ADD_STAGES = `FP_ADD_STAGES;
endpackage

// File: rtl/gfx_fp_stream_fifo.sv
// Synchronous result FIFO for the FP stream adapter. The full and empty flags
// are decoded from the registered occupancy count only, so they never depend on
// this cycle's push or pop.
module gfx_fp_stream_fifo
  import gfx_fp_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  fp    data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output fp    head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fp                mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pushOk, popOk;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;
  assign head_o  = mem_q[rdPtr_q];

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popOk)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/gfx_fp_stream.sv
// Valid/ready adapter around a fixed-latency, stall-controlled gfx FP pipeline.
// Optional perf counters are built when GFX_FP_STREAM_PERF_EN is defined.
module gfx_fp_stream
  import gfx_fp_stream_pkg::*;
#(
  parameter int unsigned LATENCY = FP_ADD_STAGES,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  fp           in_a_i,
  input  fp           in_b_i,
  output fp           pipe_a_o,
  output fp           pipe_b_o,
  output logic        pipe_stall_o,
  input  fp           pipe_q_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output fp           out_q_o
`ifdef GFX_FP_STREAM_PERF_EN
  ,
  output logic [31:0] perf_ops_o,
  output logic [31:0] perf_stall_cycles_o
`endif
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic               vLast, fifoFull, fifoEmpty;
  logic               accept, push, pop;

  assign pipe_a_o     = in_a_i;
  assign pipe_b_o     = in_b_i;
  assign vLast        = valid_q[LATENCY-1];
  // Registered full flag keeps out_ready off the combinational stall path.
  assign pipe_stall_o = vLast && fifoFull;
  assign in_ready_o   = !pipe_stall_o;
  assign accept       = in_valid_i && in_ready_o;
  assign push         = vLast && !fifoFull;
  assign pop          = out_valid_o && out_ready_i;
  assign out_valid_o  = !fifoEmpty;

  always_comb begin
    valid_d = valid_q;
    if (!pipe_stall_o) begin
      valid_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  gfx_fp_stream_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (pipe_q_i),
    .pop_i   (pop),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (out_q_o)
  );

`ifdef GFX_FP_STREAM_PERF_EN
  logic [31:0] perfOps_q, perfOps_d;
  logic [31:0] perfStall_q, perfStall_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    perfOps_d   = perfOps_q;
    perfStall_d = perfStall_q;
    if (pop && (perfOps_q != '1))            perfOps_d   = perfOps_q + 32'd1;
    if (pipe_stall_o && (perfStall_q != '1)) perfStall_d = perfStall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perfOps_q   <= '0;
      perfStall_q <= '0;
    end else begin
      perfOps_q   <= perfOps_d;
      perfStall_q <= perfStall_d;
    end
  end

  assign perf_ops_o          = perfOps_q;
  assign perf_stall_cycles_o = perfStall_q;
`endif

endmodule

// File: tb/tb_gfx_fp_stream.sv
// Bench for gfx_fp_stream with a stall-able 4-stage adder model and a
// result scoreboard; perf checks are built with GFX_FP_STREAM_PERF_EN.
module tb_gfx_fp_stream;
  import gfx_fp_stream_pkg::*;

  localparam int LAT = 4;
  localparam int DEP = 4;

  typedef struct {
    fp  value;
    int cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inValid = 1'b0;
  logic inReady;
  fp    inA = '0;
  fp    inB = '0;
  fp    pipeA, pipeB, pipeQ;
  logic pipeStall;
  logic outValid;
  logic outReady = 1'b0;
  fp    outQ;
`ifdef GFX_FP_STREAM_PERF_EN
  logic [31:0] perfOps, perfStall;
`endif

  exp_t expQ[$];
  fp    stage [LAT];
  int   cycleNo = 0;
  int   checks = 0;
  int   errors = 0;
  int   stallSeen = 0;
  logic sInReady, sOutValid, sPipeStall, sAcc, sPopped;
  fp    sOutQ;

  always #5 clk = ~clk;

  gfx_fp_stream #(
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .in_valid_i          (inValid),
    .in_ready_o          (inReady),
    .in_a_i              (inA),
    .in_b_i              (inB),
    .pipe_a_o            (pipeA),
    .pipe_b_o            (pipeB),
    .pipe_stall_o        (pipeStall),
    .pipe_q_i            (pipeQ),
    .out_valid_o         (outValid),
    .out_ready_i         (outReady),
    .out_q_o             (outQ)
`ifdef GFX_FP_STREAM_PERF_EN
    ,
    .perf_ops_o          (perfOps),
    .perf_stall_cycles_o (perfStall)
`endif
  );

  // Stand-in FP adder: raw-operand sum, four stages, frozen while stalled.
  always @(posedge clk) begin
    if (!pipeStall) begin
      stage[0] <= pipeA + pipeB;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end
  assign pipeQ = stage[LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, update the scoreboard, advance.
  task automatic applyStimulus(input logic inV, input fp a, input fp b, input logic outR);
    inValid = inV;
    inA = a;
    inB = b;
    outReady = outR;
    #3;
    sInReady   = inReady;
    sOutValid  = outValid;
    sPipeStall = pipeStall;
    sOutQ      = outQ;
    sAcc       = inValid && inReady;
    sPopped    = outValid && outReady;
    if (sPipeStall) stallSeen++;
    if (sAcc) expQ.push_back('{a + b, cycleNo});
    if (sPopped) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousResult", 32'(sOutValid), 32'd0);
      end else begin
        exp_t e = expQ.pop_front();
        checkOutput("resultData", sOutQ, e.value);
        checkOutput("resultLatency", 32'((cycleNo - e.cycle) >= (LAT + 1)), 32'd1);
      end
    end
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    stallSeen = 0;
    cycleNo = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;
    int firstPop;
    int maxOut;
    int budget;

    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("resetOutValid", 32'(sOutValid), 32'd0);
    checkOutput("resetInReady", 32'(sInReady), 32'd1);
    checkOutput("resetStall", 32'(sPipeStall), 32'd0);
`ifdef GFX_FP_STREAM_PERF_EN
    checkOutput("resetPerfOps", perfOps, 32'd0);
    checkOutput("resetPerfStall", perfStall, 32'd0);
`endif

    $display("[TB] single op");
    applyStimulus(1'b1, 32'd1, 32'd2, 1'b1);
    checkOutput("singleAccept", 32'(sAcc), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("singleValid", 32'(sOutValid), 32'(k == 5));
      if (k == 5) checkOutput("singleQ", sOutQ, 32'd3);
    end

    $display("[TB] back-to-back");
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1'(k < 16), $urandom, $urandom, 1'b1);
      if (k < 16) checkOutput("b2bReady", 32'(sInReady), 32'd1);
      checkOutput("b2bValid", 32'(sOutValid), 32'((k >= 5) && (k <= 20)));
    end
    checkOutput("b2bDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] backpressure");
    doReset();
    sent = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'(sent < 10), $urandom, $urandom, 1'b0);
      if (sAcc) sent++;
    end
    checkOutput("bpAccepted", 32'(sent), 32'd8);
    checkOutput("bpInReady", 32'(sInReady), 32'd0);
    checkOutput("bpStall", 32'(sPipeStall), 32'd1);
    checkOutput("bpHeadHeld", sOutQ, expQ[0].value);
    firstPop = -1;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'(sent < 10), $urandom, $urandom, 1'b1);
      if (sAcc) sent++;
      if (firstPop >= 0 && k == firstPop + 1) checkOutput("bpReadyAfterPop", 32'(sInReady), 32'd1);
      if (sPopped && firstPop < 0) begin
        firstPop = k;
        checkOutput("bpReadyAtPop", 32'(sInReady), 32'd0);
      end
    end
    checkOutput("bpFirstPopSeen", 32'(firstPop >= 0), 32'd1);
    checkOutput("bpAllSent", 32'(sent), 32'd10);
    checkOutput("bpDrained", 32'(expQ.size()), 32'd0);
`ifdef GFX_FP_STREAM_PERF_EN
    checkOutput("perfOps", perfOps, 32'd10);
    checkOutput("perfStallCycles", perfStall, 32'(stallSeen));
`endif

    $display("[TB] random traffic");
    sent = 0;
    maxOut = 0;
    budget = 0;
    while (sent < 1000 && budget < 20000) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (sAcc) sent++;
      if (expQ.size() > maxOut) maxOut = expQ.size();
      budget++;
    end
    checkOutput("randAllSent", 32'(sent), 32'd1000);
    checkOutput("randMaxInFlight", 32'(maxOut <= LAT + DEP), 32'd1);
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("randDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] reset mid-flight");
    for (int k = 0; k < 6; k++) applyStimulus(1'(k < 5), $urandom, $urandom, 1'b0);
    checkOutput("preRstValid", 32'(sOutValid), 32'd1);
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("rstOutValid", 32'(sOutValid), 32'd0);
    checkOutput("rstInReady", 32'(sInReady), 32'd1);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("noStaleResult", 32'(sOutValid), 32'd0);
    end
    applyStimulus(1'b1, 32'd40, 32'd2, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("postRstDrained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
